mgmt_uart_tx: RTL and testbench

MGMT_UART_TX -- requirements
Module: mgmt_uart_tx

---
 rtl/mgmt_uart_tx.sv | 158 +++++++++++++++
 tb/tb_mgmt_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_uart_tx.sv
// Management UART transmitter: byte FIFO feeding an 8N1 serializer with a
// per-frame latched bit-period divisor. All outputs except wr_ready are flops.
module mgmt_uart_tx #(
   parameter int DEPTH     = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [DIV_WIDTH-1:0]   divisor,
   input  logic                   wr_valid,
   input  logic [7:0]             wr_data,
   output logic                   wr_ready,
   output logic                   ser_tx,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   tx_done,
   output logic [1:0]             dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [7:0]           shreg_q, shreg_d;
   logic [2:0]           bit_q, bit_d;
   logic                 ser_tx_q, ser_tx_d;
   logic                 busy_q, busy_d;
   logic                 tx_done_q, tx_done_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          level_q, level_d;
   logic [7:0]           mem_q [DEPTH];

   logic                 push, pop, last_stop;
   logic [DIV_WIDTH-1:0] div_eff;

   // Handshake: a byte is taken on any cycle with wr_valid && wr_ready; wr_ready
   // depends only on the registered level, never on a same-cycle pop.
   assign wr_ready  = (level_q != FULL);
   assign push      = wr_valid && wr_ready;
   assign last_stop = (state_q == S_STOP) && (cnt_q == '0);
   assign pop       = ((state_q == S_IDLE) || last_stop) && enable && (level_q != '0);
   assign div_eff   = (divisor == '0) ? DIV_ONE : divisor;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      case (state_q)
         S_START: begin
            if (cnt_q == '0) begin
               state_d = S_DATA;
               cnt_d   = div_q - DIV_ONE;
               bit_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - DIV_ONE;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = div_q - DIV_ONE;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q - DIV_ONE;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - DIV_ONE;
         end
         default: ;
      endcase
      // A pop on the last stop cycle overrides the return to idle: no gap.
      if (pop) begin
         state_d = S_START;
         div_d   = div_eff;
         cnt_d   = div_eff - DIV_ONE;
         shreg_d = mem_q[rd_ptr_q];
         bit_d   = 3'd0;
      end
   end

   always_comb begin
      case (state_d)
         S_START: ser_tx_d = 1'b0;
         S_DATA:  ser_tx_d = shreg_d[0];
         default: ser_tx_d = 1'b1;
      endcase
      busy_d    = (state_d != S_IDLE);
      tx_done_d = (state_d == S_STOP) && (cnt_d == '0);
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= DIV_ONE;
         shreg_q   <= '0;
         bit_q     <= '0;
         ser_tx_q  <= 1'b1;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shreg_q   <= shreg_d;
         bit_q     <= bit_d;
         ser_tx_q  <= ser_tx_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign ser_tx     = ser_tx_q;
   assign busy       = busy_q;
   assign tx_done    = tx_done_q;
   assign fifo_level = level_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mgmt_uart_tx.sv
// Bench for mgmt_uart_tx: frame table, hand-written corner sequences and random
// traffic, all checked against a waveform-queue reference model every cycle.
module tb_mgmt_uart_tx;

   localparam int DEPTH = 8;
   localparam int DW    = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [DW-1:0] divisor = 16'd4;
   logic          wr_valid = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_ready, ser_tx, busy, tx_done;
   logic [3:0]    fifo_level;
   logic [1:0]    dbg_state;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   mgmt_uart_tx #(.DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .divisor(divisor),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .ser_tx(ser_tx), .busy(busy), .fifo_level(fifo_level),
      .tx_done(tx_done), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // exp_q holds queued bytes; wave_q holds the expected line level for every
   // remaining clock of the frame in flight (head = current cycle).
   logic [7:0] exp_q[$];
   bit         wave_q[$];
   int         sim_pp = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         wave_q.delete();
      end else begin : model_step
         int   lvl0, d;
         bit   m_pop, m_push, lv;
         logic [7:0] b;
         lvl0   = exp_q.size();
         m_pop  = (wave_q.size() <= 1) && enable && (lvl0 != 0);
         m_push = wr_valid && (lvl0 != DEPTH);
         if (wave_q.size() != 0) void'(wave_q.pop_front());
         if (m_pop) begin
            b = exp_q.pop_front();
            d = (divisor == 0) ? 1 : int'(divisor);
            for (int k = 0; k < 10; k++) begin
               lv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
               for (int r = 0; r < d; r++) wave_q.push_back(lv);
            end
         end
         if (m_push) exp_q.push_back(wr_data);
         if (m_push && m_pop) sim_pp++;
      end
   end

   // ---------------- scoreboard + monitors ----------------
   int done_cnt = 0;
   int busy_cyc = 0;
   int run_cur  = 0;
   int last_run = 0;

   always @(negedge clock) begin
      if (!reset) begin
         if (tx_done) done_cnt++;
         if (busy) begin
            busy_cyc++;
            run_cur++;
         end else if (run_cur != 0) begin
            last_run = run_cur;
            run_cur  = 0;
         end
      end
      if (!reset && chk_en) begin : sb
         bit e_busy;
         e_busy = (wave_q.size() != 0);
         check("ser_tx", 32'(ser_tx), 32'(e_busy ? wave_q[0] : 1'b1));
         check("busy", 32'(busy), 32'(e_busy));
         check("tx_done", 32'(tx_done), 32'(wave_q.size() == 1));
         check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
         check("wr_ready", 32'(wr_ready), 32'(exp_q.size() != DEPTH));
         check("state_active", 32'(dbg_state != 2'd0), 32'(e_busy));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_valid = 1'b1;
      wr_data  = b;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int quiet = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         if (busy || (enable && fifo_level != 0)) quiet = 0;
         else quiet++;
         if (quiet == 3) break;
      end
      check("idle_reached", 32'(quiet), 32'd3);
      tick();
   endtask

   // ---------------- frame vector table ----------------
   typedef struct {
      logic [7:0]    data;
      logic [DW-1:0] div;
      logic [9:0]    frame;   // bit j = j-th bit period on the line
      int            cycles;
   } vec_t;

   localparam int NV = 6;
   vec_t vecs[NV];

   initial begin : watchdog
      #600000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : test
      int lat, de, bad, bn, dn, di, d0, b0, pushed, guard;

      vecs[0] = '{8'hA5, 16'd4, 10'b1_10100101_0, 40};
      vecs[1] = '{8'h3C, 16'd1, 10'b1_00111100_0, 10};
      vecs[2] = '{8'h00, 16'd0, 10'b1_00000000_0, 10};
      vecs[3] = '{8'hFF, 16'd3, 10'b1_11111111_0, 30};
      vecs[4] = '{8'h81, 16'd2, 10'b1_10000001_0, 20};
      vecs[5] = '{8'h55, 16'd5, 10'b1_01010101_0, 50};

      // reset values while reset is held
      repeat (3) @(posedge clock);
      #1;
      check("rst_ser_tx", 32'(ser_tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_done", 32'(tx_done), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
      reset  = 1'b0;
      chk_en = 1'b1;
      enable = 1'b1;
      repeat (2) tick();

      // single frames from an idle, empty FIFO
      for (int k = 0; k < NV; k++) begin
         divisor = vecs[k].div;
         write_byte(vecs[k].data);
         lat = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            lat++;
            if (!ser_tx) break;
         end
         check("start_latency", 32'(lat), 32'd2);
         de  = (vecs[k].div == 0) ? 1 : int'(vecs[k].div);
         bad = 0; bn = 0; dn = 0; di = -1;
         for (int j = 0; j < vecs[k].cycles + 2; j++) begin
            if (j > 0) @(negedge clock);
            if (j < vecs[k].cycles && ser_tx !== vecs[k].frame[j / de]) bad++;
            if (busy) bn++;
            if (tx_done) begin
               dn++;
               di = j;
            end
         end
         check("frame_bits", 32'(bad), 32'd0);
         check("busy_len", 32'(bn), 32'(vecs[k].cycles));
         check("done_count", 32'(dn), 32'd1);
         check("done_idx", 32'(di), 32'(vecs[k].cycles - 1));
         tick();
      end

      // back-to-back frames with no idle gap
      divisor = 16'd2;
      d0 = done_cnt;
      write_byte(8'h41);
      write_byte(8'h42);
      write_byte(8'h43);
      wait_idle(400);
      check("b2b_run", 32'(last_run), 32'd60);
      check("b2b_done", 32'(done_cnt - d0), 32'd3);

      // full FIFO with transmitter held off; ninth byte dropped
      enable  = 1'b0;
      divisor = 16'd1;
      for (int i = 0; i < 8; i++) write_byte(8'(i));
      check("full_level", 32'(fifo_level), 32'd8);
      check("full_wr_ready", 32'(wr_ready), 32'd0);
      write_byte(8'h08);
      check("full_level_after_drop", 32'(fifo_level), 32'd8);
      d0 = done_cnt;
      enable = 1'b1;
      wait_idle(500);
      check("full_drain_done", 32'(done_cnt - d0), 32'd8);

      // pointer wrap with shallow level and simultaneous push/pop
      divisor = 16'd1;
      d0 = done_cnt;
      b0 = sim_pp;
      pushed = 0;
      guard = 0;
      while (pushed < 20 && guard < 2000) begin
         guard++;
         if (exp_q.size() < 3) begin
            write_byte(8'($urandom_range(0, 255)));
            pushed++;
         end else begin
            tick();
         end
      end
      wait_idle(500);
      check("wrap_done", 32'(done_cnt - d0), 32'd20);
      check("wrap_pushpop_seen", 32'(sim_pp - b0 > 0), 32'd1);

      // enable drop and divisor change mid-frame
      divisor = 16'd4;
      write_byte(8'h55);
      write_byte(8'h66);
      repeat (5) tick();
      divisor = 16'd8;
      enable  = 1'b0;
      wait_idle(500);
      check("mid_run_old_div", 32'(last_run), 32'd40);
      b0 = busy_cyc;
      repeat (20) tick();
      check("mid_no_start", 32'(busy_cyc - b0), 32'd0);
      check("mid_level_held", 32'(fifo_level), 32'd1);
      enable = 1'b1;
      wait_idle(500);
      check("mid_run_new_div", 32'(last_run), 32'd80);

      // asynchronous reset during the data bits
      divisor = 16'd4;
      write_byte(8'h3C);
      write_byte(8'hAA);
      write_byte(8'hBB);
      repeat (8) tick();
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_ser_tx", 32'(ser_tx), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_level", 32'(fifo_level), 32'd0);
      check("arst_tx_done", 32'(tx_done), 32'd0);
      check("arst_wr_ready", 32'(wr_ready), 32'd1);
      repeat (2) tick();
      reset = 1'b0;
      b0 = busy_cyc;
      repeat (30) tick();
      check("post_rst_quiet", 32'(busy_cyc - b0), 32'd0);
      write_byte(8'h3C);
      wait_idle(500);
      check("post_rst_frame", 32'(last_run), 32'd40);

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         if (c % 60 == 0) divisor = 16'($urandom_range(0, 3));
         enable   = ($urandom_range(0, 7) != 0);
         wr_valid = ($urandom_range(0, 2) == 0);
         wr_data  = 8'($urandom_range(0, 255));
         tick();
      end
      wr_valid = 1'b0;
      enable   = 1'b1;
      wait_idle(2000);
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
